// File: rtl/sdram_row_controller.sv
// Single open-row write-back buffer between a 32-bit word requester and a whole-row SDRAM bank.
// Hits are served from the row buffer; misses write back a dirty row, then fetch the requested row.
module sdram_row_controller #(
  parameter int ROW_BITS  = 13,
  parameter int WORD_BITS = 9
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [ROW_BITS+WORD_BITS-1:0]        address,
  input  logic                                 read,
  input  logic                                 write,
  input  logic [31:0]                          writedata,
  input  logic [3:0]                           byteenable,
  output logic                                 waitrequest,
  output logic [31:0]                          readdata,
  output logic                                 readdatavalid,
  output logic                                 bank_write_enable,
  output logic [ROW_BITS-1:0]                  bank_column_address,
  input  logic                                 bank_wait_signal,
  output logic [(1<<WORD_BITS)-1:0][31:0]      bank_row_out,
  input  logic [(1<<WORD_BITS)-1:0][31:0]      bank_row_in
);

  localparam int WORDS = 1 << WORD_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, CAPTURE} state_t;

  state_t                   state;
  logic [WORDS-1:0][31:0]   buffer;
  logic [ROW_BITS-1:0]      tag;
  logic [ROW_BITS-1:0]      fetch_row;
  logic                     valid;
  logic                     dirty;
  logic [ROW_BITS-1:0]      req_row;
  logic [WORD_BITS-1:0]     req_word;
  logic                     hit;
  logic                     accept;
  logic                     bank_ready;

  assign req_row     = address[ROW_BITS+WORD_BITS-1:WORD_BITS];
  assign req_word    = address[WORD_BITS-1:0];
  assign hit         = valid && (tag == req_row);
  assign waitrequest = !((state == IDLE) && hit);
  assign accept      = (read || write) && !waitrequest;

  // The buffer is stable outside IDLE, so it can drive the bank directly during WRITEBACK.
  assign bank_row_out = buffer;

  // Only an explicit 1 stalls; an unknown wait signal takes the default and counts as ready.
  always_comb begin
    bank_ready = 1'b1;
    if (bank_wait_signal == 1'b1) bank_ready = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      buffer              <= '0;
      tag                 <= '0;
      fetch_row           <= '0;
      valid               <= 1'b0;
      dirty               <= 1'b0;
      readdata            <= '0;
      readdatavalid       <= 1'b0;
      bank_write_enable   <= 1'b0;
      bank_column_address <= '0;
    end else begin
      readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (write) begin
              for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) buffer[req_word][8*b +: 8] <= writedata[8*b +: 8];
              end
              dirty <= 1'b1;
            end else begin
              readdata      <= buffer[req_word];
              readdatavalid <= 1'b1;
            end
          end else if (read || write) begin
            fetch_row <= req_row;
            if (valid && dirty) begin
              bank_write_enable   <= 1'b1;
              bank_column_address <= tag;
              state               <= WRITEBACK;
            end else begin
              bank_column_address <= req_row;
              state               <= FETCH;
            end
          end
        end
        WRITEBACK: begin
          if (bank_ready) begin
            dirty               <= 1'b0;
            bank_write_enable   <= 1'b0;
            bank_column_address <= fetch_row;
            state               <= FETCH;
          end
        end
        FETCH: begin
          if (bank_ready) state <= CAPTURE;
        end
        CAPTURE: begin
          buffer <= bank_row_in;
          tag    <= fetch_row;
          valid  <= 1'b1;
          dirty  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_row_controller.sv
// Bench for sdram_row_controller: behavioural bank plus a flat word-memory model with one open row.
// Table vectors, hand-written corner sequences, then randomized traffic with random refresh stalls.
module tb_sdram_row_controller;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic [21:0]          address;
  logic                 read;
  logic                 write;
  logic [31:0]          writedata;
  logic [3:0]           byteenable;
  logic                 waitrequest;
  logic [31:0]          readdata;
  logic                 readdatavalid;
  logic                 bank_write_enable;
  logic [12:0]          bank_column_address;
  logic                 bank_wait_signal;
  logic [511:0][31:0]   bank_row_out;
  logic [511:0][31:0]   bank_row_in;

  int n_cmp = 0;
  int n_fail = 0;
  int stall_cnt = 0;
  int bank_writes = 0;
  int wait_mode = 0;
  logic rand_wait = 1'b0;

  logic [511:0][31:0] bank_rows [int];
  logic [31:0] ref_bank [int];
  logic [31:0] overlay [int];
  bit m_valid = 0;
  int m_row = 0;
  bit m_dirty = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [21:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          waits;
    logic        rdv;
    logic [31:0] rdata;
  } vec_t;

  sdram_row_controller dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid), .bank_write_enable(bank_write_enable),
    .bank_column_address(bank_column_address), .bank_wait_signal(bank_wait_signal),
    .bank_row_out(bank_row_out), .bank_row_in(bank_row_in)
  );

  always #5 clock = ~clock;

  always @(negedge clock) rand_wait = ($urandom_range(0, 3) == 0);
  assign bank_wait_signal = (wait_mode == 1) || ((wait_mode == 2) && rand_wait);

  function automatic logic [31:0] init_word(int a);
    logic [31:0] x;
    x = 32'(a);
    return (x * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  function automatic logic [511:0][31:0] bank_fetch(int row);
    logic [511:0][31:0] r;
    if (bank_rows.exists(row)) return bank_rows[row];
    for (int w = 0; w < 512; w++) r[w] = init_word((row << 9) | w);
    return r;
  endfunction

  // Bank: registered row read, whole-row write, ignores commands while the wait signal is high.
  always @(posedge clock) begin
    if (bank_wait_signal === 1'b1) begin
      stall_cnt++;
    end else begin
      if (bank_write_enable === 1'b1) begin
        bank_rows[int'(bank_column_address)] = bank_row_out;
        bank_writes++;
      end
      bank_row_in <= bank_fetch(int'(bank_column_address));
    end
  end

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_word(int a);
    if (overlay.exists(a)) return overlay[a];
    if (ref_bank.exists(a)) return ref_bank[a];
    return init_word(a);
  endfunction

  function automatic int model_latency(int row);
    if (m_valid && m_row == row) return 0;
    if (m_valid && m_dirty) return 4;
    return 3;
  endfunction

  function automatic void model_access(bit wr, int a, logic [31:0] d, logic [3:0] be);
    int row;
    row = a >> 9;
    if (!(m_valid && m_row == row)) begin
      if (m_valid && m_dirty) foreach (overlay[k]) ref_bank[k] = overlay[k];
      overlay.delete();
      m_valid = 1;
      m_row = row;
      m_dirty = 0;
    end
    if (wr) begin
      overlay[a] = merge(model_word(a), d, be);
      m_dirty = 1;
    end
  endfunction

  function automatic void model_reset();
    overlay.delete();
    m_valid = 0;
    m_dirty = 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Call at (or just after) a falling edge; returns at a falling edge one cycle after acceptance.
  task automatic applyStimulus(input logic rd_i, input logic wr_i, input logic [21:0] a,
                               input logic [31:0] d, input logic [3:0] be,
                               output int waits, output logic rdv, output logic [31:0] rdata,
                               output int stalls);
    int s0;
    s0 = stall_cnt;
    read = rd_i; write = wr_i; address = a; writedata = d; byteenable = be;
    waits = 0;
    #1;
    while (waitrequest !== 1'b0 && waits < 1000) begin
      waits++;
      @(negedge clock); #1;
    end
    if (waits >= 1000) checkOutput("accept_timeout", 32'(waits), 32'd0);
    @(posedge clock); #1;
    stalls = stall_cnt - s0;
    read = 1'b0; write = 1'b0;
    @(negedge clock);
    rdv = readdatavalid;
    rdata = readdata;
  endtask

  initial begin
    vec_t vecs[8];
    int waits, stalls, bad, w0, exp_lat, pulses;
    logic rdv;
    logic [31:0] rdata, exp_data, merged203;
    logic [511:0][31:0] tmp_row;
    logic [21:0] a;
    logic rd, wr;

    merged203 = init_word(22'h203);
    merged203 = {merged203[31:24], 8'hAD, merged203[15:8], 8'hEF};
    vecs[0] = '{1'b1, 1'b0, 22'h000005, 32'h0,        4'h0, 3, 1'b1, init_word(22'h005)};
    vecs[1] = '{1'b0, 1'b1, 22'h000203, 32'hDEADBEEF, 4'h5, 3, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 22'h000203, 32'h0,        4'h0, 0, 1'b1, merged203};
    vecs[3] = '{1'b1, 1'b0, 22'h000204, 32'h0,        4'h0, 0, 1'b1, init_word(22'h204)};
    vecs[4] = '{1'b1, 1'b1, 22'h000204, 32'h12345678, 4'hF, 0, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 22'h000204, 32'h0,        4'h0, 0, 1'b1, 32'h12345678};
    vecs[6] = '{1'b0, 1'b1, 22'h000205, 32'hFFFFFFFF, 4'h0, 0, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 22'h000205, 32'h0,        4'h0, 0, 1'b1, init_word(22'h205)};

    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0; byteenable = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_rdv", readdatavalid, 1'b0);
    checkOutput("reset_write_enable", bank_write_enable, 1'b0);
    checkOutput("reset_column", bank_column_address, 13'h0);
    checkOutput("reset_row_out0", bank_row_out[0], 32'h0);
    reset_n = 1'b1;
    #1 checkOutput("reset_waitrequest", waitrequest, 1'b1);
    @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be, waits, rdv, rdata, stalls);
      model_access(vecs[i].wr, int'(vecs[i].addr), vecs[i].data, vecs[i].be);
      checkOutput($sformatf("vec%0d_waits", i), 32'(waits), 32'(vecs[i].waits));
      checkOutput($sformatf("vec%0d_rdv", i), rdv, vecs[i].rdv);
      if (vecs[i].rdv) checkOutput($sformatf("vec%0d_readdata", i), rdata, vecs[i].rdata);
    end

    // Dirty row 1 evicted by a read of row 2.
    read = 1'b1; write = 1'b0; address = 22'h000400;
    #1 checkOutput("dirty_miss_wait", waitrequest, 1'b1);
    @(negedge clock); #1;
    checkOutput("wb_write_enable", bank_write_enable, 1'b1);
    checkOutput("wb_column", bank_column_address, 13'd1);
    checkOutput("wb_row_word3", bank_row_out[3], merged203);
    checkOutput("wb_row_word4", bank_row_out[4], 32'h12345678);
    @(negedge clock); #1;
    checkOutput("fetch_write_enable", bank_write_enable, 1'b0);
    checkOutput("fetch_column", bank_column_address, 13'd2);
    @(negedge clock); #1;
    checkOutput("capture_wait", waitrequest, 1'b1);
    @(negedge clock); #1;
    checkOutput("dirty_miss_accept", waitrequest, 1'b0);
    @(posedge clock); #1; read = 1'b0;
    @(negedge clock);
    checkOutput("dirty_miss_rdv", readdatavalid, 1'b1);
    checkOutput("dirty_miss_data", readdata, init_word(22'h400));
    model_access(0, 22'h400, 0, 0);
    tmp_row = bank_fetch(1);
    bad = 0;
    for (int w = 0; w < 512; w++) if (tmp_row[w] !== model_word((1 << 9) | w)) bad++;
    checkOutput("bank_row1_image", 32'(bad), 32'd0);

    // Long refresh stall while fetching row 3.
    w0 = bank_writes;
    read = 1'b1; address = 22'h000600; wait_mode = 1;
    #1 checkOutput("stall_initial_wait", waitrequest, 1'b1);
    bad = 0;
    for (int k = 0; k < 67; k++) begin
      @(negedge clock); #1;
      if (bank_column_address !== 13'd3 || bank_write_enable !== 1'b0 || waitrequest !== 1'b1) bad++;
    end
    checkOutput("stall_outputs_stable", 32'(bad), 32'd0);
    wait_mode = 0;
    @(negedge clock); #1;
    checkOutput("stall_capture_wait", waitrequest, 1'b1);
    @(negedge clock); #1;
    checkOutput("stall_accept", waitrequest, 1'b0);
    @(posedge clock); #1; read = 1'b0;
    @(negedge clock);
    checkOutput("stall_rdv", readdatavalid, 1'b1);
    checkOutput("stall_data", readdata, init_word(22'h600));
    checkOutput("stall_no_bank_write", 32'(bank_writes), 32'(w0));
    model_access(0, 22'h600, 0, 0);

    // 100 back-to-back hit reads in row 3.
    pulses = 0;
    for (int i = 0; i <= 100; i++) begin
      read = (i < 100);
      address = {13'd3, 9'(i)};
      #1;
      if (i < 100) checkOutput("burst_waitrequest", waitrequest, 1'b0);
      if (i > 0) begin
        if (readdatavalid === 1'b1) pulses++;
        checkOutput("burst_readdata", readdata, model_word((3 << 9) | (i - 1)));
      end
      @(negedge clock);
    end
    checkOutput("burst_pulses", 32'(pulses), 32'd100);
    #1 checkOutput("burst_rdv_ends", readdatavalid, 1'b0);

    // Reset asserted in WRITEBACK discards the dirty row.
    applyStimulus(1'b0, 1'b1, 22'h000600, 32'hCAFEF00D, 4'hF, waits, rdv, rdata, stalls);
    model_access(1, 22'h600, 32'hCAFEF00D, 4'hF);
    checkOutput("pre_reset_write_waits", 32'(waits), 32'd0);
    read = 1'b1; address = 22'h000800;
    @(negedge clock); #1;
    checkOutput("rst_wb_write_enable", bank_write_enable, 1'b1);
    checkOutput("rst_wb_column", bank_column_address, 13'd3);
    w0 = bank_writes;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_write_enable", bank_write_enable, 1'b0);
    checkOutput("rst_column", bank_column_address, 13'd0);
    checkOutput("rst_waitrequest", waitrequest, 1'b1);
    read = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    #1 checkOutput("rst_no_partial_write", 32'(bank_writes), 32'(w0));
    applyStimulus(1'b1, 1'b0, 22'h000600, 32'h0, 4'h0, waits, rdv, rdata, stalls);
    model_access(0, 22'h600, 0, 0);
    checkOutput("refetch_waits", 32'(waits), 32'd3);
    checkOutput("refetch_rdv", rdv, 1'b1);
    checkOutput("refetch_data", rdata, init_word(22'h600));

    // Random traffic over a few rows with random refresh stalls.
    wait_mode = 2;
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      rd = (sel < 5) || (sel == 9);
      wr = (sel >= 5);
      a = {13'(3 + $urandom_range(0, 3)), 9'($urandom_range(0, 15))};
      exp_lat = model_latency(int'(a) >> 9);
      exp_data = model_word(int'(a));
      writedata = $urandom;
      byteenable = 4'($urandom_range(0, 15));
      applyStimulus(rd, wr, a, writedata, byteenable, waits, rdv, rdata, stalls);
      model_access(wr, int'(a), writedata, byteenable);
      if (stalls == 0) checkOutput("rand_latency", 32'(waits), 32'(exp_lat));
      else checkOutput("rand_latency_range", (waits >= exp_lat && waits <= exp_lat + stalls), 1'b1);
      if (rd && !wr) begin
        checkOutput("rand_rdv", rdv, 1'b1);
        checkOutput("rand_readdata", rdata, exp_data);
      end else begin
        checkOutput("rand_no_rdv", rdv, 1'b0);
      end
    end
    wait_mode = 0;
    bad = 0;
    foreach (ref_bank[k]) begin
      tmp_row = bank_fetch(k >> 9);
      if (tmp_row[k & 511] !== ref_bank[k]) bad++;
    end
    checkOutput("final_bank_image", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
